regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates the single register-file write port between the core writeback
// path and a debug/loader path. Writeback has priority, but a waiting debug
// request is guaranteed a slot after STARVE_LIMIT consecutive writeback grants.
// Writes are registered: an accepted request appears on rf_* one cycle later.
// Writes to register 0 are accepted but never reach the register file.
//
// Optional feature, macro RF_SCRUB_EN: after reset the block first clears
// registers 1..31 (one per cycle, busy=1, no grants), then enters RUN.
// Without the macro the block resets straight into RUN and busy is tied 0.
//
// Ports:
//   Clk        in   1   system clock, rising edge
//   Rst        in   1   asynchronous active-high reset
//   cpu_enable in   1   global stall; low blocks all new grants
//   wb_valid   in   1   writeback request
//   wb_addr    in   5   writeback destination register
//   wb_data    in   32  writeback data
//   wb_ready   out  1   writeback accepted (combinational)
//   dbg_valid  in   1   debug write request
//   dbg_addr   in   5   debug destination register
//   dbg_data   in   32  debug data
//   dbg_ready  out  1   debug accepted (combinational)
//   rf_we      out  1   register-file write enable (registered)
//   rf_addr    out  5   register-file write address (registered)
//   rf_wdata   out  32  register-file write data (registered)
//   busy       out  1   scrub in progress
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        cpu_enable,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        dbg_valid,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        dbg_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        run;
  logic        scrubbing;
  logic [4:0]  scrub_addr;

  logic [3:0]  starve_cnt;
  logic [3:0]  starve_cnt_next;
  logic        rf_we_next;
  logic [4:0]  rf_addr_next;
  logic [31:0] rf_wdata_next;

`ifdef RF_SCRUB_EN
  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] scrub_cnt;
  logic [4:0] scrub_cnt_next;

  // State register and scrub address counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= SCRUB;
      scrub_cnt <= 5'd1;
    end else begin
      state     <= state_next;
      scrub_cnt <= scrub_cnt_next;
    end
  end

  // Next-state logic: leave SCRUB once register 31 has been written.
  always_comb begin
    state_next     = state;
    scrub_cnt_next = scrub_cnt;
    case (state)
      SCRUB: begin
        if (scrub_cnt == 5'd31) begin
          state_next     = RUN;
          scrub_cnt_next = 5'd1;
        end else begin
          state_next     = SCRUB;
          scrub_cnt_next = scrub_cnt + 5'd1;
        end
      end
      RUN: begin
        state_next     = RUN;
        scrub_cnt_next = scrub_cnt;
      end
      default: begin
        state_next     = SCRUB;
        scrub_cnt_next = 5'd1;
      end
    endcase
  end

  assign run        = (state == RUN);
  assign scrubbing  = (state == SCRUB);
  assign scrub_addr = scrub_cnt;
`else
  assign run        = 1'b1;
  assign scrubbing  = 1'b0;
  assign scrub_addr = 5'd0;
`endif

  assign busy = scrubbing;

  // Grant selection: writeback first, debug when wb idle or wb has used up
  // its allowance of consecutive grants while debug waited.
  always_comb begin
    wb_ready  = 1'b0;
    dbg_ready = 1'b0;
    if (run && cpu_enable) begin
      if (dbg_valid && (!wb_valid || (starve_cnt == LIMIT))) begin
        dbg_ready = 1'b1;
      end else if (wb_valid) begin
        wb_ready = 1'b1;
      end else begin
        wb_ready  = 1'b0;
        dbg_ready = 1'b0;
      end
    end else begin
      wb_ready  = 1'b0;
      dbg_ready = 1'b0;
    end
  end

  // Starvation counter update: counts writeback wins over a waiting debug.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!run || !cpu_enable) begin
      starve_cnt_next = starve_cnt;
    end else if (dbg_ready || !dbg_valid) begin
      starve_cnt_next = 4'd0;
    end else if (wb_ready) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end else begin
      starve_cnt_next = starve_cnt;
    end
  end

  // Write-port next values; address/data only move on a real write so that
  // they hold their last value whenever rf_we is low (including x0 writes).
  always_comb begin
    rf_we_next    = 1'b0;
    rf_addr_next  = rf_addr;
    rf_wdata_next = rf_wdata;
    if (scrubbing) begin
      rf_we_next    = 1'b1;
      rf_addr_next  = scrub_addr;
      rf_wdata_next = 32'd0;
    end else if (wb_valid && wb_ready) begin
      if (wb_addr != 5'd0) begin
        rf_we_next    = 1'b1;
        rf_addr_next  = wb_addr;
        rf_wdata_next = wb_data;
      end else begin
        rf_we_next = 1'b0;
      end
    end else if (dbg_valid && dbg_ready) begin
      if (dbg_addr != 5'd0) begin
        rf_we_next    = 1'b1;
        rf_addr_next  = dbg_addr;
        rf_wdata_next = dbg_data;
      end else begin
        rf_we_next = 1'b0;
      end
    end else begin
      rf_we_next = 1'b0;
    end
  end

  // Output and counter registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rf_we      <= 1'b0;
      rf_addr    <= 5'd0;
      rf_wdata   <= 32'd0;
      starve_cnt <= 4'd0;
    end else begin
      rf_we      <= rf_we_next;
      rf_addr    <= rf_addr_next;
      rf_wdata   <= rf_wdata_next;
      starve_cnt <= starve_cnt_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Randomized and directed stimulus against a reference model of the
// arbitration rules. Every accepted write to a nonzero register is pushed into
// a queue with the cycle it must appear in; a separate monitor pops and
// compares whenever rf_we is high, and checks that rf_addr/rf_wdata hold
// while rf_we is low. Build with +define+RF_SCRUB_EN to include scrub checks.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int SL = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        cpu_enable = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        wb_ready;
  logic        dbg_valid = 1'b0;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data = 32'd0;
  logic        dbg_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        busy;

  regfile_write_arbiter #(.STARVE_LIMIT(SL)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .cpu_enable (cpu_enable),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_ready  (dbg_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mon_cyc = 0;
  logic [4:0]  last_a = 5'd0;
  logic [31:0] last_d = 32'd0;

  // Reference model state
  int streak = 0;      // consecutive wb wins while debug was waiting
  int scrub_left = 0;  // scrub writes still to come

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = mon_cyc + 1;
    w.a   = a;
    w.d   = d;
    exp_q.push_back(w);
  endtask

  // Monitor: compares the registered write port once per clock.
  always @(posedge Clk) begin
    wr_t w;
    #1;
    mon_cyc++;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rf_addr}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("wr_cycle", mon_cyc, w.cyc);
        check("wr_addr", {27'd0, rf_addr}, {27'd0, w.a});
        check("wr_data", rf_wdata, w.d);
      end
      last_a = rf_addr;
      last_d = rf_wdata;
    end else begin
      check("hold_addr", {27'd0, rf_addr}, {27'd0, last_a});
      check("hold_data", rf_wdata, last_d);
      if (exp_q.size() != 0 && exp_q[0].cyc <= mon_cyc) begin
        w = exp_q.pop_front();
        check("missing_write", {31'd0, rf_we}, 32'd1);
      end
    end
  end

  // One stimulus cycle, called at a falling edge; returns at the next one.
  task automatic do_cycle(input logic en, input logic wv, input logic [4:0] wa,
                          input logic [31:0] wd, input logic dv,
                          input logic [4:0] da, input logic [31:0] dd);
    logic ew, ed;
    cpu_enable = en;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    #1;
    ew = 1'b0;
    ed = 1'b0;
    if (scrub_left == 0 && en) begin
      if (dv && (!wv || streak >= SL)) ed = 1'b1;
      else if (wv) ew = 1'b1;
    end
    check("wb_ready", {31'd0, wb_ready}, {31'd0, ew});
    check("dbg_ready", {31'd0, dbg_ready}, {31'd0, ed});
    check("busy", {31'd0, busy}, {31'd0, (scrub_left > 0)});
    if (scrub_left > 0) begin
      push_wr(5'(32 - scrub_left), 32'd0);
      scrub_left--;
    end else if (en) begin
      if (ed) begin
        streak = 0;
        if (da != 5'd0) push_wr(da, dd);
      end else if (ew) begin
        streak = dv ? streak + 1 : 0;
        if (wa != 5'd0) push_wr(wa, wd);
      end else begin
        streak = 0;
      end
    end
    @(negedge Clk);
  endtask

  task automatic rand_cycle();
    do_cycle(($urandom_range(0, 9) != 0), 1'($urandom), 5'($urandom), $urandom,
             1'($urandom), 5'($urandom), $urandom);
  endtask

  // Reset pulse, called at a falling edge; releases at the next one.
  task automatic pulse_rst();
    Rst = 1'b1;
    #1;
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_addr", {27'd0, rf_addr}, 32'd0);
    check("rst_data", rf_wdata, 32'd0);
    exp_q.delete();
    last_a = 5'd0;
    last_d = 32'd0;
    streak = 0;
`ifdef RF_SCRUB_EN
    scrub_left = 31;
`else
    scrub_left = 0;
`endif
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    @(negedge Clk);
    @(negedge Clk);
    pulse_rst();
`ifdef RF_SCRUB_EN
    // Reset in the middle of the scrub, right after register 17 was written.
    for (int i = 0; i < 17; i++) rand_cycle();
    check("scrub_at_17", {27'd0, rf_addr}, 32'd17);
    pulse_rst();
`endif
    // Scrub window (no-op stimulus check when scrub is compiled out).
    for (int i = 0; i < 31; i++) rand_cycle();
    do_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // Basic writeback.
    do_cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    // Sustained contention: 4 wb grants then 1 debug grant, repeating.
    for (int i = 0; i < 15; i++)
      do_cycle(1'b1, 1'b1, 5'(i + 1), 32'h1000 + i, 1'b1, 5'd30, 32'hD000 + i);
    // Stall mid-streak: counter must survive the stall.
    do_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++)
      do_cycle(1'b1, 1'b1, 5'd7, 32'h700 + i, 1'b1, 5'd9, 32'h900);
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 1'b1, 5'd7, 32'h7FF, 1'b1, 5'd9, 32'h9FF);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 1'b1, 5'd8, 32'h800 + i, 1'b1, 5'd10, 32'hA00 + i);
    // Debug write to x0: accepted, no register-file write.
    do_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    do_cycle(1'b1, 1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
    // Random traffic.
    for (int i = 0; i < 300; i++) rand_cycle();
    // Reset in the middle of RUN traffic, then more traffic.
    pulse_rst();
    for (int i = 0; i < 120; i++) rand_cycle();
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
